// File: rtl/ro_sensor_pkg.sv
// Shared types and defaults for the ring-oscillator measurement sequencer.
// Holds the FSM state encoding, oscillator ids and default timing parameters.
package ro_sensor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_COUNT  = 3'd2,
        ST_LATCH  = 3'd3,
        ST_REPORT = 3'd4
    } seq_state_t;

    localparam logic OSC_INV  = 1'b0;
    localparam logic OSC_NAND = 1'b1;

    localparam int DEF_SETTLE_CYC = 16;
    localparam int DEF_WINDOW_CYC = 1024;
    localparam int DEF_CNT_W      = 16;

    localparam int          TIMER_W   = 16;
    localparam logic [15:0] LATCH_CYC = 16'd2;

    function automatic logic first_osc(input logic [1:0] mask);
        return mask[0] ? OSC_INV : OSC_NAND;
    endfunction

endpackage

// File: rtl/ro_seq_timer.sv
// Loadable 16-bit down-counter; done flags the last cycle of a loaded interval.
// Load takes effect on the next edge; stops at zero, no backpressure.
module ro_seq_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] value,
    output logic        done
);

    logic [15:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 16'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
        end
    end

    assign value = cnt;
    assign done  = (cnt == 16'd1);

endmodule

// File: rtl/ro_measure_sequencer.sv
// Sequences settle/count/latch/report for the inverter and NAND ring oscillators.
// All outputs registered (aligned with state); result held until res_valid&res_ready.
module ro_measure_sequencer
    import ro_sensor_pkg::*;
#(
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int WINDOW_CYC = DEF_WINDOW_CYC,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    input  logic             stop,
    input  logic [1:0]       osc_mask,
    output logic             en_inv_osc,
    output logic             en_nand_osc,
    output logic             osc_sel,
    output logic             cnt_clr,
    output logic             cnt_gate,
    input  logic [CNT_W-1:0] cnt_value,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_data,
    output logic             res_osc,
    output logic             busy
);

    localparam logic [15:0] SETTLE_LD = 16'(SETTLE_CYC);
    localparam logic [15:0] WINDOW_LD = 16'(WINDOW_CYC);

    seq_state_t state, state_n;
    logic       osc_cur, osc_n;
    logic [1:0] mask_q, mask_n;
    logic       stop_pending, stop_pend_n;

    logic        t_load;
    logic [15:0] t_load_val;
    logic [15:0] t_value;
    logic        t_done;

    logic en_inv_n, en_nand_n, osc_sel_n, cnt_clr_n, cnt_gate_n, res_valid_n, busy_n;
    logic xfer;
    logic capture;

    assign xfer    = res_valid && res_ready;
    assign capture = (state == ST_LATCH) && (t_value == 16'd1);

    ro_seq_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .load_val (t_load_val),
        .value    (t_value),
        .done     (t_done)
    );

    // State register, output registers and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            osc_cur      <= OSC_INV;
            mask_q       <= 2'b00;
            stop_pending <= 1'b0;
            en_inv_osc   <= 1'b0;
            en_nand_osc  <= 1'b0;
            osc_sel      <= 1'b0;
            cnt_clr      <= 1'b0;
            cnt_gate     <= 1'b0;
            res_valid    <= 1'b0;
            busy         <= 1'b0;
            res_data     <= '0;
            res_osc      <= 1'b0;
        end else begin
            state        <= state_n;
            osc_cur      <= osc_n;
            mask_q       <= mask_n;
            stop_pending <= stop_pend_n;
            en_inv_osc   <= en_inv_n;
            en_nand_osc  <= en_nand_n;
            osc_sel      <= osc_sel_n;
            cnt_clr      <= cnt_clr_n;
            cnt_gate     <= cnt_gate_n;
            res_valid    <= res_valid_n;
            busy         <= busy_n;
            if (capture) begin
                res_data <= cnt_value;
                res_osc  <= osc_cur;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_n     = state;
        osc_n       = osc_cur;
        mask_n      = mask_q;
        stop_pend_n = stop_pending;
        case (state)
            ST_IDLE: begin
                if (start && !stop && (osc_mask != 2'b00)) begin
                    state_n = ST_SETTLE;
                    mask_n  = osc_mask;
                    osc_n   = first_osc(osc_mask);
                end
            end
            ST_SETTLE: begin
                if (stop)        state_n = ST_IDLE;
                else if (t_done) state_n = ST_COUNT;
            end
            ST_COUNT: begin
                if (stop)        state_n = ST_IDLE;
                else if (t_done) state_n = ST_LATCH;
            end
            ST_LATCH: begin
                if (stop)   stop_pend_n = 1'b1;
                if (t_done) state_n = ST_REPORT;
            end
            ST_REPORT: begin
                if (stop) stop_pend_n = 1'b1;
                if (xfer) begin
                    // A stop seen during LATCH/REPORT ends the sweep after this result
                    if (stop_pending || stop) begin
                        state_n = ST_IDLE;
                    end else if ((osc_cur == OSC_INV) && mask_q[1]) begin
                        state_n = ST_SETTLE;
                        osc_n   = OSC_NAND;
                    end else if (cont && (osc_mask != 2'b00)) begin
                        state_n = ST_SETTLE;
                        mask_n  = osc_mask;
                        osc_n   = first_osc(osc_mask);
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (state_n == ST_IDLE) stop_pend_n = 1'b0;
    end

    // Output logic: computed from the next state so registered outputs track state
    always_comb begin
        t_load      = (state_n != state);
        t_load_val  = 16'd0;
        case (state_n)
            ST_SETTLE: t_load_val = SETTLE_LD;
            ST_COUNT:  t_load_val = WINDOW_LD;
            ST_LATCH:  t_load_val = LATCH_CYC;
            default:   t_load_val = 16'd0;
        endcase
        en_inv_n    = ((state_n == ST_SETTLE) || (state_n == ST_COUNT)) && (osc_n == OSC_INV);
        en_nand_n   = ((state_n == ST_SETTLE) || (state_n == ST_COUNT)) && (osc_n == OSC_NAND);
        osc_sel_n   = (state_n != ST_IDLE) ? osc_n : 1'b0;
        cnt_clr_n   = (state_n == ST_SETTLE);
        cnt_gate_n  = (state_n == ST_COUNT);
        res_valid_n = (state_n == ST_REPORT);
        busy_n      = (state_n != ST_IDLE);
    end

endmodule

// File: tb/tb_ro_measure_sequencer.sv
// Directed bench for the ring-oscillator sequencer with SETTLE_CYC=4, WINDOW_CYC=8.
module tb_ro_measure_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  osc_mask = 2'b00;
    logic        en_inv_osc, en_nand_osc, osc_sel, cnt_clr, cnt_gate;
    logic [15:0] cnt_value;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        res_osc;
    logic        busy;

    logic [15:0] inv_val  = 16'h1234;
    logic [15:0] nand_val = 16'hBEEF;

    int n_total = 0;
    int n_bad   = 0;

    // Counter model: value depends on which oscillator the mux selects
    assign cnt_value = osc_sel ? nand_val : inv_val;

    always #5 clk = ~clk;

    ro_measure_sequencer #(
        .SETTLE_CYC (4),
        .WINDOW_CYC (8),
        .CNT_W      (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cont        (cont),
        .stop        (stop),
        .osc_mask    (osc_mask),
        .en_inv_osc  (en_inv_osc),
        .en_nand_osc (en_nand_osc),
        .osc_sel     (osc_sel),
        .cnt_clr     (cnt_clr),
        .cnt_gate    (cnt_gate),
        .cnt_value   (cnt_value),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_osc     (res_osc),
        .busy        (busy)
    );

    typedef struct {
        logic [15:0] data;
        logic        osc;
        int          nand_at;
    } xfer_t;

    xfer_t xq[$];
    int inv_cyc = 0, nand_cyc = 0, gate_cyc = 0, clr_cyc = 0, overlap_cyc = 0;

    always @(negedge clk) begin
        if (en_inv_osc)                inv_cyc++;
        if (en_nand_osc)               nand_cyc++;
        if (cnt_gate)                  gate_cyc++;
        if (cnt_clr)                   clr_cyc++;
        if (en_inv_osc && en_nand_osc) overlap_cyc++;
        if (res_valid && res_ready) begin
            xfer_t x;
            x.data    = res_data;
            x.osc     = res_osc;
            x.nand_at = nand_cyc;
            xq.push_back(x);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return busy;
            1:       return res_valid;
            default: return cnt_gate;
        endcase
    endfunction

    task automatic wait_sig(input int which, input logic val, input int budget, input string tag);
        int n = 0;
        while (sig(which) !== val && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {31'b0, sig(which)}, {31'b0, val});
    endtask

    task automatic wait_xfers(input int target, input int budget, input string tag);
        int n = 0;
        while (xq.size() < target && n < budget) begin
            tick();
            n++;
        end
        chk(tag, xq.size(), target);
    endtask

    function automatic logic [31:0] all_outs();
        return {16'h0, res_data, 1'b0, en_inv_osc, en_nand_osc, osc_sel, cnt_clr, cnt_gate,
                res_valid, res_osc, busy} & 32'hFFFF_FFFF;
    endfunction

    task automatic pulse_start(input logic [1:0] m);
        osc_mask = m;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    initial begin
        int b_inv, b_nand, b_gate, b_clr, b_x, unstable;
        logic [15:0] d0;

        // Reset state
        repeat (3) tick();
        chk("reset_outs", all_outs(), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", {31'b0, busy}, 32'd0);

        // Single inverter sweep
        b_inv = inv_cyc; b_nand = nand_cyc; b_gate = gate_cyc; b_clr = clr_cyc; b_x = xq.size();
        res_ready = 1'b1;
        pulse_start(2'b01);
        chk("t1_first_cycle", {29'b0, en_inv_osc, cnt_clr, osc_sel}, {29'b0, 3'b110});
        wait_sig(0, 1'b0, 100, "t1_done");
        chk("t1_inv_cyc",  inv_cyc - b_inv, 12);
        chk("t1_nand_cyc", nand_cyc - b_nand, 0);
        chk("t1_gate_cyc", gate_cyc - b_gate, 8);
        chk("t1_clr_cyc",  clr_cyc - b_clr, 4);
        chk("t1_nxfer",    xq.size() - b_x, 1);
        if (xq.size() > b_x) begin
            chk("t1_data", {16'b0, xq[b_x].data}, 32'h1234);
            chk("t1_osc",  {31'b0, xq[b_x].osc}, 32'd0);
        end

        // Both oscillators in one sweep
        b_nand = nand_cyc; b_x = xq.size();
        pulse_start(2'b11);
        wait_xfers(b_x + 2, 200, "t2_nxfer");
        wait_sig(0, 1'b0, 20, "t2_idle");
        chk("t2_overlap", overlap_cyc, 0);
        chk("t2_nand_cyc", nand_cyc - b_nand, 12);
        if (xq.size() >= b_x + 2) begin
            chk("t2_osc0",    {31'b0, xq[b_x].osc}, 32'd0);
            chk("t2_osc1",    {31'b0, xq[b_x+1].osc}, 32'd1);
            chk("t2_data1",   {16'b0, xq[b_x+1].data}, 32'hBEEF);
            chk("t2_nand_pre", xq[b_x].nand_at - b_nand, 0);
        end

        // Backpressure in REPORT
        res_ready = 1'b0;
        b_x = xq.size();
        pulse_start(2'b01);
        wait_sig(1, 1'b1, 100, "t3_valid");
        d0 = res_data;
        chk("t3_data", {16'b0, d0}, 32'h1234);
        inv_val  = 16'h5555;
        unstable = 0;
        repeat (20) begin
            tick();
            if (res_valid !== 1'b1 || res_data !== d0) unstable++;
        end
        chk("t3_stable", unstable, 0);
        res_ready = 1'b1;
        tick();
        chk("t3_drop", {31'b0, res_valid}, 32'd0);
        chk("t3_nxfer", xq.size() - b_x, 1);
        inv_val = 16'h1234;

        // Continuous NAND sweeps, then stop during COUNT
        b_x = xq.size();
        cont = 1'b1;
        pulse_start(2'b10);
        wait_xfers(b_x + 2, 200, "t4_nxfer");
        if (xq.size() >= b_x + 2) begin
            chk("t4_osc", {30'b0, xq[b_x].osc, xq[b_x+1].osc}, 32'd3);
            chk("t4_data", {16'b0, xq[b_x+1].data}, 32'hBEEF);
        end
        wait_sig(2, 1'b1, 50, "t4_gate");
        stop = 1'b1;
        cont = 1'b0;
        tick();
        stop = 1'b0;
        chk("t4_abort", {28'b0, busy, cnt_gate, en_nand_osc, cnt_clr}, 32'd0);
        repeat (30) tick();
        chk("t4_no_extra", xq.size() - b_x, 2);

        // Stop in REPORT: result delivered, second oscillator skipped
        res_ready = 1'b0;
        b_x = xq.size(); b_nand = nand_cyc;
        pulse_start(2'b11);
        wait_sig(1, 1'b1, 100, "t5_valid");
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t5_hold", {31'b0, res_valid}, 32'd1);
        res_ready = 1'b1;
        tick();
        chk("t5_idle", {30'b0, busy, res_valid}, 32'd0);
        chk("t5_nxfer", xq.size() - b_x, 1);
        chk("t5_nand_cyc", nand_cyc - b_nand, 0);
        pulse_start(2'b00);
        repeat (3) tick();
        chk("t5_mask0", {31'b0, busy}, 32'd0);
        osc_mask = 2'b01;
        stop  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("t5_start_stop", {31'b0, busy}, 32'd0);

        // Asynchronous reset during COUNT
        b_x = xq.size();
        pulse_start(2'b01);
        wait_sig(2, 1'b1, 50, "t6_gate");
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async", {16'b0, en_inv_osc, en_nand_osc, osc_sel, cnt_clr, cnt_gate,
                         res_valid, res_osc, busy, 8'b0}, 32'd0);
        chk("t6_data0", {16'b0, res_data}, 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (30) tick();
        chk("t6_no_result", {31'b0, res_valid}, 32'd0);
        chk("t6_nxfer", xq.size() - b_x, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ro_measure_sequencer.md
RO_MEASURE_SEQUENCER -- requirements
Module: ro_measure_sequencer

Interface
REQ-001 Parameter SETTLE_CYC, default 16: oscillator settle cycles before counting; legal range 1..65535.
REQ-002 Parameter WINDOW_CYC, default 1024: counting-gate length in clk cycles; legal range 1..65535.
REQ-003 Parameter CNT_W, default 16: width of the external edge count and of the result.
REQ-004 clk  in  1  single system clock; all logic rising-edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse, request one sweep.
REQ-007 cont  in  1  level, repeat sweeps while high.
REQ-008 stop  in  1  one-cycle pulse, end measurement.
REQ-009 osc_mask  in  2  bit0 inverter RO, bit1 NAND RO; sampled at sweep start.
REQ-010 en_inv_osc  out  1  inverter ring-oscillator enable.
REQ-011 en_nand_osc  out  1  NAND ring-oscillator enable.
REQ-012 osc_sel  out  1  counter source mux, 0=inverter, 1=NAND.
REQ-013 cnt_clr  out  1  synchronous clear of the external counter.
REQ-014 cnt_gate  out  1  external counter enable (counting window).
REQ-015 cnt_value  in  CNT_W  external counter value, already synchronised to clk.
REQ-016 res_valid  out  1  result available.
REQ-017 res_ready  in  1  consumer (UART framer) accepts result.
REQ-018 res_data  out  CNT_W  captured count.
REQ-019 res_osc  out  1  oscillator id of res_data (0=inv, 1=nand).
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 FSM states IDLE, SETTLE, COUNT, LATCH, REPORT; all outputs registered.
REQ-022 IDLE: start=1 with osc_mask!=0 and stop=0 -> SETTLE next cycle; mask latched; first oscillator = inverter if bit0 set, else NAND.
REQ-023 start with osc_mask=0, start while busy, or start together with stop in IDLE: ignored, no state change.
REQ-024 SETTLE: exactly SETTLE_CYC cycles; only selected oscillator enable high; osc_sel = selected id; cnt_clr=1, cnt_gate=0.
REQ-025 COUNT: exactly WINDOW_CYC cycles; enable held; cnt_clr=0, cnt_gate=1.
REQ-026 LATCH: exactly 2 cycles; both enables 0, cnt_gate=0; res_data<=cnt_value at end of 2nd cycle (synchroniser drain).
REQ-027 REPORT: res_valid=1; res_data/res_osc stable until res_valid&res_ready; transfer takes one cycle, res_valid drops next cycle.
REQ-028 After transfer: other masked oscillator not yet measured in this sweep -> SETTLE with it; else cont=1 and no pending stop -> new sweep (mask re-sampled, mask=0 -> IDLE); else IDLE.
REQ-029 stop in SETTLE or COUNT: abort to IDLE next cycle; enables, cnt_gate, cnt_clr low; no result produced.
REQ-030 stop in LATCH or REPORT: set stop_pending; current result completes, then IDLE; stop_pending cleared on entering IDLE.
REQ-031 Never both oscillator enables high in the same cycle.
REQ-032 Count saturation is the external counter's concern; res_data is cnt_value unmodified.

Reset
REQ-033 rst_n low: state IDLE, all outputs 0, timer 0, stop_pending 0, latched mask 0, asynchronously.
REQ-034 Reset mid-sweep discards the sweep; no res_valid after release until a new start.

Structure
REQ-035 Package ro_sensor_pkg holds the state enum, OSC_INV=0/OSC_NAND=1 constants and default SETTLE_CYC/WINDOW_CYC/CNT_W values.
REQ-036 One sub-module ro_seq_timer: 16-bit loadable down-counter with load, value and done (count==1) signals, reused for SETTLE, COUNT and LATCH.

Verification (SETTLE_CYC=4, WINDOW_CYC=8, CNT_W=16)
REQ-037 Mask=01, start, cnt_value=0x1234, res_ready=1 -> en_inv_osc high 12 cycles, cnt_gate high 8, res_data=0x1234, res_osc=0, busy low afterward.
REQ-038 Mask=11, start -> two results, res_osc 0 then 1, enables never overlap, en_nand_osc rises only after the first transfer.
REQ-039 res_ready held low 20 cycles in REPORT -> res_valid and res_data stable 20 cycles, single transfer on ready.
REQ-040 cont=1, mask=10 -> back-to-back NAND results; stop pulse during COUNT -> IDLE next cycle, no extra res_valid.
REQ-041 stop in REPORT -> current result delivered, then IDLE; start with mask=00 -> busy stays 0.
REQ-042 rst_n low during COUNT -> all outputs 0 immediately, no result after release.
